lsd_segment_fifo: RTL and testbench

- Downstream consumer of the line-segment detector output.
- Captures each valid segment (start/end coordinates, min/max angle) emitted during an outputting burst and drops degenerate short segments.
- Queues accepted segments in a first-word-fall-through FIFO with a valid/ready read port, for the lane-geometry / steering stage.
- Reports per-burst statistics: accepted count, overflow flag, and a completion pulse.

---
 rtl/lsd_segment_fifo.sv | 230 +++++++++++++++++++++++
 tb/tb_lsd_segment_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lsd_segment_fifo.sv
// lsd_segment_fifo
//   Consumer of the line-segment detector. During an outputting burst every
//   valid segment is registered, its Manhattan length is computed, and short
//   segments are dropped. Surviving segments go into a first-word-fall-through
//   FIFO read through a valid/ready port. Per-burst statistics are kept.
//
//   Optional feature macro: SEG_ANGLE_FILTER_EN
//     When defined, a segment is also dropped unless
//     ANG_LO <= (min_a+max_a)>>1 <= ANG_HI.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_outputting         detector burst-active flag
//   in_valid              segment fields valid this cycle
//   in_start_v/h, in_end_v/h, in_min_a, in_max_a   segment fields
//   rd_valid / rd_ready   FIFO head handshake
//   rd_*                  head segment fields (zero while empty)
//   fifo_level            occupancy 0..DEPTH
//   frame_done            one-cycle pulse at burst close
//   seg_count             segments accepted in the last closed burst
//   overflow              sticky: a segment was lost in the current/last burst
module lsd_segment_fifo #(
  parameter int WIDTH   = 858,
  parameter int HEIGHT  = 525,
  parameter int DEPTH   = 64,
  parameter int MIN_LEN = 8,
  parameter int CNT_W   = 8
`ifdef SEG_ANGLE_FILTER_EN
  ,
  parameter int ANG_LO  = 32,
  parameter int ANG_HI  = 224
`endif
  ,
  localparam int H_BITW = $clog2(WIDTH),
  localparam int V_BITW = $clog2(HEIGHT),
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_outputting,
  input  logic              in_valid,
  input  logic [V_BITW-1:0] in_start_v,
  input  logic [H_BITW-1:0] in_start_h,
  input  logic [V_BITW-1:0] in_end_v,
  input  logic [H_BITW-1:0] in_end_h,
  input  logic [7:0]        in_min_a,
  input  logic [7:0]        in_max_a,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [V_BITW-1:0] rd_start_v,
  output logic [H_BITW-1:0] rd_start_h,
  output logic [V_BITW-1:0] rd_end_v,
  output logic [H_BITW-1:0] rd_end_h,
  output logic [7:0]        rd_min_a,
  output logic [7:0]        rd_max_a,
  output logic [AW:0]       fifo_level,
  output logic              frame_done,
  output logic [CNT_W-1:0]  seg_count,
  output logic              overflow
);

  localparam int LW = ((H_BITW > V_BITW) ? H_BITW : V_BITW) + 2;
  localparam logic [LW-1:0] MIN_L    = LW'(MIN_LEN);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [V_BITW-1:0] sv;
    logic [H_BITW-1:0] sh;
    logic [V_BITW-1:0] ev;
    logic [H_BITW-1:0] eh;
    logic [7:0]        mina;
    logic [7:0]        maxa;
  } seg_t;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  // ---------------- burst FSM ----------------
  state_t state_q, state_d;
  logic   outp_q;     // previous in_outputting, for edge detection
  logic   start;      // burst entry: clears counter and overflow

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      IDLE:    if (in_outputting && !outp_q) begin
                 state_d = CAPTURE;
                 start   = 1'b1;
               end
      CAPTURE: if (!in_outputting) state_d = DRAIN;
      // in_outputting was low on the cycle that led here, so high now is a
      // new rising edge: close this burst and open the next back to back.
      DRAIN:   if (in_outputting) begin
                 state_d = CAPTURE;
                 start   = 1'b1;
               end else begin
                 state_d = IDLE;
               end
      default: state_d = IDLE;
    endcase
  end

  // Capture only inside a burst (or on its opening cycle); after a reset the
  // burst must be re-armed by a fresh rising edge.
  logic capture;
  assign capture = in_outputting && in_valid && ((state_q == CAPTURE) || start);
  assign frame_done = (state_q == DRAIN);

  // ---------------- stage 1 ----------------
  logic s1_vld_q;
  seg_t s1_q, s1_d;

  always_comb begin
    s1_d      = s1_q;
    if (capture) begin
      s1_d.sv   = in_start_v;
      s1_d.sh   = in_start_h;
      s1_d.ev   = in_end_v;
      s1_d.eh   = in_end_h;
      s1_d.mina = in_min_a;
      s1_d.maxa = in_max_a;
    end
  end

  logic [LW-1:0] sv_x, ev_x, sh_x, eh_x, dv, dh, len;
  logic          keep;

  assign sv_x = LW'(s1_q.sv);
  assign ev_x = LW'(s1_q.ev);
  assign sh_x = LW'(s1_q.sh);
  assign eh_x = LW'(s1_q.eh);
  assign dv   = (ev_x >= sv_x) ? (ev_x - sv_x) : (sv_x - ev_x);
  assign dh   = (eh_x >= sh_x) ? (eh_x - sh_x) : (sh_x - eh_x);
  assign len  = dv + dh;  // two operands each < 2^(LW-2): cannot wrap

`ifdef SEG_ANGLE_FILTER_EN
  logic [8:0] ang_sum;
  logic [7:0] mid;
  assign ang_sum = {1'b0, s1_q.mina} + {1'b0, s1_q.maxa};
  assign mid     = ang_sum[8:1];
  assign keep    = (len >= MIN_L) && (mid >= 8'(ANG_LO)) && (mid <= 8'(ANG_HI));
`else
  assign keep    = (len >= MIN_L);
`endif

  // ---------------- FIFO ----------------
  seg_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_req, push_ok, pop;
  seg_t          head;

  assign rd_valid = (level_q != '0);
  assign pop      = rd_valid && rd_ready;
  assign push_req = s1_vld_q && keep;
  // A pop on a full FIFO frees the slot being written this same edge.
  assign push_ok  = push_req && ((level_q < FULL_LVL) || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= s1_q;
  end

  assign head       = mem_q[rd_ptr_q];
  assign rd_start_v = rd_valid ? head.sv   : '0;
  assign rd_start_h = rd_valid ? head.sh   : '0;
  assign rd_end_v   = rd_valid ? head.ev   : '0;
  assign rd_end_h   = rd_valid ? head.eh   : '0;
  assign rd_min_a   = rd_valid ? head.mina : '0;
  assign rd_max_a   = rd_valid ? head.maxa : '0;
  assign fifo_level = level_q;

  // ---------------- statistics ----------------
  logic [CNT_W-1:0] cnt_q, cnt_d, segc_q, segc_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    segc_d = segc_q;
    if (start)                         cnt_d = '0;
    else if (push_ok && cnt_q != '1)   cnt_d = cnt_q + 1'b1;
    if (start)                         ovf_d = 1'b0;
    else if (push_req && !push_ok)     ovf_d = 1'b1;
    if (state_q == DRAIN)              segc_d = cnt_q;
  end

  assign seg_count = segc_q;
  assign overflow  = ovf_q;

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      outp_q   <= 1'b1;  // blocks a spurious rise if the burst is still high
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      segc_q   <= '0;
    end else begin
      state_q  <= state_d;
      outp_q   <= in_outputting;
      s1_vld_q <= capture;
      s1_q     <= s1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      segc_q   <= segc_d;
    end
  end

endmodule

// File: tb/tb_lsd_segment_fifo.sv
// Directed bench for lsd_segment_fifo (default parameters, DEPTH=64).
module tb_lsd_segment_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_outputting, in_valid, rd_ready;
  logic [9:0] in_start_v, in_start_h, in_end_v, in_end_h;
  logic [7:0] in_min_a, in_max_a;
  logic       rd_valid;
  logic [9:0] rd_start_v, rd_start_h, rd_end_v, rd_end_h;
  logic [7:0] rd_min_a, rd_max_a;
  logic [6:0] fifo_level;
  logic       frame_done, overflow;
  logic [7:0] seg_count;

  int errors = 0;
  int checks = 0;

  lsd_segment_fifo dut (
    .clk(clk), .rst(rst),
    .in_outputting(in_outputting), .in_valid(in_valid),
    .in_start_v(in_start_v), .in_start_h(in_start_h),
    .in_end_v(in_end_v), .in_end_h(in_end_h),
    .in_min_a(in_min_a), .in_max_a(in_max_a),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_start_v(rd_start_v), .rd_start_h(rd_start_h),
    .rd_end_v(rd_end_v), .rd_end_h(rd_end_h),
    .rd_min_a(rd_min_a), .rd_max_a(rd_max_a),
    .fifo_level(fifo_level), .frame_done(frame_done),
    .seg_count(seg_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic seg(input int sv, input int sh, input int ev, input int eh,
                     input int mina, input int maxa);
    in_start_v = 10'(sv);
    in_start_h = 10'(sh);
    in_end_v   = 10'(ev);
    in_end_h   = 10'(eh);
    in_min_a   = 8'(mina);
    in_max_a   = 8'(maxa);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_outputting = 1'b0; in_valid = 1'b0; rd_ready = 1'b0;
    seg(0, 0, 0, 0, 0, 0);
    tick; tick;
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_seg_count", seg_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rd_start_v", rd_start_v, 0);
    rst = 1'b0;
    tick;

    // ---- single burst, one long segment ----
    in_outputting = 1'b1; in_valid = 1'b1;
    seg(10, 20, 30, 25, 100, 110);
    tick;
    chk("t1_lat1_rd_valid", rd_valid, 0);
    in_valid = 1'b0;
    tick;
    chk("t1_rd_valid", rd_valid, 1);
    chk("t1_start_v", rd_start_v, 10);
    chk("t1_start_h", rd_start_h, 20);
    chk("t1_end_v", rd_end_v, 30);
    chk("t1_end_h", rd_end_h, 25);
    chk("t1_min_a", rd_min_a, 100);
    chk("t1_max_a", rd_max_a, 110);
    chk("t1_level", fifo_level, 1);
    chk("t1_no_done", frame_done, 0);
    in_outputting = 1'b0;
    tick;
    chk("t1_done", frame_done, 1);
    tick;
    chk("t1_done_off", frame_done, 0);
    chk("t1_seg_count", seg_count, 1);
    rd_ready = 1'b1;
    tick;
    rd_ready = 1'b0;
    chk("t1_pop_empty", rd_valid, 0);
    chk("t1_pop_level", fifo_level, 0);

    // ---- short drop; length 7 dropped, length 8 (reversed) kept ----
    in_outputting = 1'b1; in_valid = 1'b1;
    seg(5, 5, 7, 8, 0, 0);          // len 5
    tick;
    seg(0, 0, 3, 4, 0, 0);          // len 7
    tick;
    seg(100, 54, 96, 50, 0, 0);     // len 8, both deltas negative
    tick;
    in_valid = 1'b0;
    chk("t2_short_level", fifo_level, 0);
    tick;
    chk("t2_len8_level", fifo_level, 1);
    chk("t2_len8_start_v", rd_start_v, 100);
    in_outputting = 1'b0;
    tick;
    chk("t2_done", frame_done, 1);
    tick;
    chk("t2_seg_count", seg_count, 1);
    rd_ready = 1'b1;
    tick;
    rd_ready = 1'b0;
    chk("t2_empty", fifo_level, 0);

    // ---- overflow: 70 segments, no reads ----
    in_outputting = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 70; i++) begin
      seg(i, 0, i, 100, 0, 0);
      tick;
    end
    in_valid = 1'b0;
    tick; tick;
    chk("t3_level_full", fifo_level, 64);
    chk("t3_overflow", overflow, 1);
    in_outputting = 1'b0;
    tick; tick;
    chk("t3_seg_count", seg_count, 64);
    chk("t3_overflow_held", overflow, 1);
    chk("t3_head", rd_start_v, 0);
    in_outputting = 1'b1;
    tick;
    chk("t3_ovf_cleared", overflow, 0);
    chk("t3_level_kept", fifo_level, 64);

    // ---- full with simultaneous pop ----
    in_valid = 1'b1;
    seg(500, 0, 500, 100, 0, 0);
    tick;
    in_valid = 1'b0; rd_ready = 1'b1;
    tick;
    rd_ready = 1'b0;
    chk("t4_level", fifo_level, 64);
    chk("t4_overflow", overflow, 0);
    chk("t4_head", rd_start_v, 1);
    in_outputting = 1'b0;
    tick; tick;
    chk("t4_seg_count", seg_count, 1);

    // ---- async reset mid-burst with 3 queued ----
    rd_ready = 1'b1;
    repeat (64) tick;
    rd_ready = 1'b0;
    chk("t5_drained", fifo_level, 0);
    in_outputting = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      seg(200 + i, 0, 200 + i, 50, 0, 0);
      tick;
    end
    in_valid = 1'b0;
    tick;
    chk("t5_level3", fifo_level, 3);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_rd_valid", rd_valid, 0);
    chk("t5_rst_level", fifo_level, 0);
    chk("t5_rst_seg_count", seg_count, 0);
    chk("t5_rst_overflow", overflow, 0);
    chk("t5_rst_start_v", rd_start_v, 0);
    tick;
    rst = 1'b0;
    in_valid = 1'b1;
    seg(300, 0, 300, 50, 0, 0);
    tick; tick;
    in_valid = 1'b0;
    tick;
    chk("t5_no_rearm", fifo_level, 0);
    in_outputting = 1'b0;
    tick;
    in_outputting = 1'b1; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    chk("t5_rearmed", fifo_level, 1);
    chk("t5_rearm_head", rd_start_v, 300);

`ifdef SEG_ANGLE_FILTER_EN
    // ---- angle filter: mid 10 dropped, mid 128 kept ----
    in_valid = 1'b1;
    seg(0, 0, 0, 50, 0, 20);
    tick;
    seg(0, 0, 0, 50, 120, 136);
    tick;
    in_valid = 1'b0;
    tick;
    chk("t6_angle_level", fifo_level, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
